// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// The optional FETCH_QUEUE_PERF_EN build uses no extra package items.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          FETCH_DEPTH_DEFAULT = 4;
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with push, pop and a flush that empties it.
// Entry storage carries no reset; only the pointers and occupancy are cleared.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);

    localparam int             PW       = $clog2(DEPTH);
    localparam int             CW       = PW + 1;
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          doPush;
    logic          doPop;

    // A full queue refuses a push even when a pop frees a slot in the same cycle.
    assign full_o = (count_q == FULL_CNT);
    assign doPush = push_i && !flush_i && !full_o;
    assign doPop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (doPush) tail_d = tail_q + PTR_ONE;
            if (doPop)  head_d = head_q + PTR_ONE;
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[tail_q] <= push_data_i;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC generation feeding a small queue of instructions for decode; redirects flush and refetch.
// Defining FETCH_QUEUE_PERF_EN adds perf_fetched/perf_flushed counters and ports.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [31:0]            dec_instr,
    output logic [31:0]            dec_pc,
    output logic [31:0]            dec_pc_plus4,
    output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_flushed
`endif
);

    logic [31:0]  pc_q, pc_d;
    logic         fifoFull;
    logic         pushFire;
    logic         popFire;
    fetch_entry_t pushEntry;
    fetch_entry_t headEntry;

    assign pushFire  = !redirect && !fifoFull;
    assign popFire   = dec_valid && dec_ready && !redirect;
    assign pushEntry = '{pc: pc_q, instr: imem_rdata};

    // The PC only advances when its instruction was actually captured.
    always_comb begin
        pc_d = pc_q;
        if (redirect)      pc_d = {redirect_pc[31:2], 2'b00};
        else if (pushFire) pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pushFire),
        .push_data_i (pushEntry),
        .pop_i       (popFire),
        .flush_i     (redirect),
        .head_o      (headEntry),
        .count_o     (count),
        .full_o      (fifoFull)
    );

    assign imem_addr    = pc_q;
    assign dec_valid    = (count != '0);
    assign dec_instr    = headEntry.instr;
    assign dec_pc       = headEntry.pc;
    assign dec_pc_plus4 = headEntry.pc + 32'd4;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perfFetched_q;
    logic [31:0] perfFlushed_q;

    // perf_flushed accumulates the entries discarded by each redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perfFetched_q <= '0;
            perfFlushed_q <= '0;
        end else begin
            if (pushFire) perfFetched_q <= perfFetched_q + 32'd1;
            if (redirect) perfFlushed_q <= perfFlushed_q + 32'(count);
        end
    end

    assign perf_fetched = perfFetched_q;
    assign perf_flushed = perfFlushed_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
// Perf counter checks are compiled in when FETCH_QUEUE_PERF_EN is defined.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [31:0]            imem_addr;
    logic [31:0]            imem_rdata;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [31:0]            dec_instr;
    logic [31:0]            dec_pc;
    logic [31:0]            dec_pc_plus4;
    logic [$clog2(DEPTH):0] count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]            perf_fetched;
    logic [31:0]            perf_flushed;
    logic [31:0]            modelFetched;
    logic [31:0]            modelFlushed;
`endif

    int checkCount = 0;
    int errorCount = 0;

    fetch_entry_t modelQ[$];
    logic [31:0]  modelPc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_pc       (dec_pc),
        .dec_pc_plus4 (dec_pc_plus4),
        .count        (count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: each word is its address scrambled with a fixed pattern.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelPc = RESET_PC;
`ifdef FETCH_QUEUE_PERF_EN
        modelFetched = '0;
        modelFlushed = '0;
`endif
    endtask

    // One clock edge of the architectural behaviour.
    task automatic modelStep(input logic rd, input logic redir, input logic [31:0] rpc);
        bit canPush;
        if (redir) begin
`ifdef FETCH_QUEUE_PERF_EN
            modelFlushed = modelFlushed + 32'(modelQ.size());
`endif
            modelQ.delete();
            modelPc = rpc & 32'hFFFF_FFFC;
        end else begin
            canPush = (modelQ.size() < DEPTH);
            if (modelQ.size() != 0 && rd) void'(modelQ.pop_front());
            if (canPush) begin
                modelQ.push_back('{pc: modelPc, instr: memWord(modelPc)});
                modelPc = modelPc + 32'd4;
`ifdef FETCH_QUEUE_PERF_EN
                modelFetched = modelFetched + 32'd1;
`endif
            end
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".valid"}, 32'(dec_valid), 32'(modelQ.size() != 0));
        checkOutput({tag, ".count"}, 32'(count), 32'(modelQ.size()));
        checkOutput({tag, ".imem_addr"}, imem_addr, modelPc);
        if (modelQ.size() != 0) begin
            checkOutput({tag, ".dec_pc"}, dec_pc, modelQ[0].pc);
            checkOutput({tag, ".dec_instr"}, dec_instr, modelQ[0].instr);
            checkOutput({tag, ".dec_pc_plus4"}, dec_pc_plus4, modelQ[0].pc + 32'd4);
        end
`ifdef FETCH_QUEUE_PERF_EN
        checkOutput({tag, ".perf_fetched"}, perf_fetched, modelFetched);
        checkOutput({tag, ".perf_flushed"}, perf_flushed, modelFlushed);
`endif
    endtask

    // Called at a falling edge: checks current outputs, drives inputs, crosses one rising edge.
    task automatic applyStimulus(input string tag, input logic rd, input logic redir, input logic [31:0] rpc);
        compareAll(tag);
        dec_ready   = rd;
        redirect    = redir;
        redirect_pc = rpc;
        @(posedge clk);
        modelStep(rd, redir, rpc);
        @(negedge clk);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        modelReset();

        @(negedge clk);
        checkOutput("reset.valid", 32'(dec_valid), 32'd0);
        checkOutput("reset.count", 32'(count), 32'd0);
        checkOutput("reset.imem_addr", imem_addr, RESET_PC);
        reset = 1'b0;

        // Streaming with decode always ready: one instruction per cycle, occupancy 1.
        for (int i = 0; i < 6; i++) applyStimulus("stream", 1'b1, 1'b0, '0);
        checkOutput("stream.count", 32'(count), 32'd1);

        // Decode stalled: the queue fills and the PC stops.
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus("stall", 1'b0, 1'b0, '0);
        checkOutput("stall.count", 32'(count), 32'd4);
        checkOutput("stall.imem_addr", imem_addr, 32'h10);
        checkOutput("stall.dec_pc", dec_pc, 32'h0);

        // One pop from full: no push in that cycle, push resumes next cycle.
        applyStimulus("fullpop", 1'b1, 1'b0, '0);
        checkOutput("fullpop.count", 32'(count), 32'd3);
        checkOutput("fullpop.imem_addr", imem_addr, 32'h10);
        applyStimulus("resume", 1'b0, 1'b0, '0);
        checkOutput("resume.count", 32'(count), 32'd4);
        checkOutput("resume.imem_addr", imem_addr, 32'h14);

        // Redirect with three entries queued; target low bits are dropped.
        applyStimulus("pre_redirect", 1'b1, 1'b0, '0);
        checkOutput("pre_redirect.count", 32'(count), 32'd3);
        applyStimulus("redirect", 1'b0, 1'b1, 32'h0000_0043);
        checkOutput("redirect.count", 32'(count), 32'd0);
        checkOutput("redirect.imem_addr", imem_addr, 32'h40);
        checkOutput("redirect.valid", 32'(dec_valid), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
        checkOutput("redirect.perf_flushed", perf_flushed, 32'd3);
`endif
        applyStimulus("refetch", 1'b0, 1'b0, '0);
        checkOutput("refetch.valid", 32'(dec_valid), 32'd1);
        checkOutput("refetch.dec_pc", dec_pc, 32'h40);

        // PC wrap across the top of the address space.
        applyStimulus("wrap_redirect", 1'b1, 1'b1, 32'hFFFF_FFF8);
        applyStimulus("wrap0", 1'b1, 1'b0, '0);
        checkOutput("wrap0.dec_pc", dec_pc, 32'hFFFF_FFF8);
        applyStimulus("wrap1", 1'b1, 1'b0, '0);
        checkOutput("wrap1.dec_pc", dec_pc, 32'hFFFF_FFFC);
        applyStimulus("wrap2", 1'b1, 1'b0, '0);
        checkOutput("wrap2.dec_pc", dec_pc, 32'h0000_0000);
        checkOutput("wrap2.dec_pc_plus4", dec_pc_plus4, 32'h0000_0004);

        // Asynchronous reset in mid-cycle with two entries queued.
        applyStimulus("grow", 1'b0, 1'b0, '0);
        checkOutput("grow.count", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1;
        checkOutput("async.valid", 32'(dec_valid), 32'd0);
        checkOutput("async.count", 32'(count), 32'd0);
        checkOutput("async.imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        applyStimulus("restart", 1'b1, 1'b0, '0);
        checkOutput("restart.dec_pc", dec_pc, RESET_PC);

        // Randomized decode back-pressure and redirects.
        for (int i = 0; i < 400; i++) begin
            logic        rd;
            logic        redir;
            logic [31:0] rpc;
            rd    = ($urandom_range(0, 3) != 0) ^ (i >= 200);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = $urandom;
            applyStimulus("random", rd, redir, rpc);
        end
        compareAll("final");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  32  current fetch PC to instruction_memory (combinational read).
REQ-006 imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-007 redirect  input  1  taken branch/jump from execute; flush and refetch.
REQ-008 redirect_pc  input  32  refetch target when redirect=1.
REQ-009 dec_valid  output  1  queue head holds a valid instruction for decode.
REQ-010 dec_ready  input  1  decode accepts head this cycle.
REQ-011 dec_instr  output  32  head instruction word.
REQ-012 dec_pc  output  32  address of head instruction.
REQ-013 dec_pc_plus4  output  32  dec_pc + 4, for branch target computation.
REQ-014 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 Fetch PC register drives imem_addr directly; no combinational path from redirect to imem_addr.
REQ-016 Push: when redirect=0 and count<DEPTH, {fetch PC, imem_rdata} written at tail, tail and PC advance, PC <= PC+4.
REQ-017 Full: count==DEPTH blocks push even if a pop occurs same cycle; PC holds.
REQ-018 Pop: dec_valid && dec_ready && redirect=0 advances head; dec_valid = (count!=0).
REQ-019 Simultaneous push and pop (count<DEPTH): count unchanged, both pointers advance.
REQ-020 Redirect dominates: count<=0, head<=tail<=0, PC<=redirect_pc with bits[1:0] forced to 0; no push, no pop that cycle.
REQ-021 First entry after redirect enqueued on the following rising edge; dec_valid high one cycle after that edge's update, i.e. 2-cycle redirect-to-valid latency.
REQ-022 Pointers wrap modulo DEPTH; PC wraps 32'hFFFF_FFFC+4 -> 32'h0000_0000.
REQ-023 Head outputs (dec_instr, dec_pc, dec_pc_plus4) driven from registered entry storage only; stable while dec_valid=1 and dec_ready=0.
REQ-024 When dec_valid=0, dec_instr/dec_pc are don't-care; bench shall not check them.

Reset
REQ-025 reset=1 asynchronously sets PC=RESET_PC, head=tail=0, count=0, dec_valid=0; entry storage not reset.
REQ-026 reset asserted mid-operation discards all entries; first push on first rising edge after deassertion, fetching RESET_PC.

Configuration
REQ-027 Macro FETCH_QUEUE_PERF_EN: when defined, adds outputs perf_fetched (32) and perf_flushed (32).
REQ-028 perf_fetched increments per push; perf_flushed adds count at each redirect; both reset to 0, wrap at 2^32.
REQ-029 Without FETCH_QUEUE_PERF_EN the ports and counters do not exist; all other behaviour identical.

Structure
REQ-030 Package fetch_pkg holds fetch_entry_t (pc[31:0], instr[31:0]), FETCH_DEPTH_DEFAULT, RESET_PC_DEFAULT.
REQ-031 Storage and pointers in sub-module fetch_fifo (push/pop/flush, count); PC logic in fetch_queue.

Verification
REQ-032 Reset, dec_ready=1, imem returns addr^32'hA5A5_0000 -> dec_pc 0,4,8,... one per cycle, dec_instr matches, count steady at 1.
REQ-033 dec_ready=0 for 8 cycles -> count reaches 4, dec_valid=1, imem_addr holds 32'h10, head stays dec_pc 0.
REQ-034 Queue full, dec_ready=1 one cycle -> one pop, no push that cycle, count 3, next cycle push resumes at 32'h10.
REQ-035 redirect=1, redirect_pc=32'h0000_0043 with count=3 -> next cycle count=0, imem_addr=32'h40, dec_valid=0; dec_valid=1 with dec_pc 32'h40 one cycle later; perf_flushed=3 when FETCH_QUEUE_PERF_EN defined.
REQ-036 redirect to 32'hFFFF_FFF8, dec_ready=1 -> dec_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; dec_pc_plus4 of last = 4.
REQ-037 reset pulse asynchronously mid-cycle with count=2 -> dec_valid falls before next edge, count=0, restart at RESET_PC.
